// File: rtl/simon_sequencer.sv
// simon_sequencer: Simon Says game engine.
// Each round grows a stored colour sequence by one random step. The whole
// sequence is then replayed on one-hot LEDs, and the player's presses are
// checked against it. The game ends in WON (at MAX_LEN) or LOST.
//
// state        | meaning
// -------------+-------------------------------------------------------
// S_IDLE       | after reset, waiting for start
// S_EXTEND     | one cycle: append rand_num, restart playback at step 0
// S_PLAY_ON    | LED for mem[idx] lit for ON_CYCLES cycles
// S_PLAY_OFF   | LEDs dark for OFF_CYCLES cycles, then next step or input
// S_WAIT_INPUT | compare each btn press with mem[idx], no timeout
// S_WON        | full MAX_LEN sequence entered correctly, all LEDs lit
// S_LOST       | wrong button pressed
module simon_sequencer #(
  parameter int MAX_LEN    = 16,
  parameter int ON_CYCLES  = 25_000_000,
  parameter int OFF_CYCLES = 12_500_000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [1:0] rand_num,
  input  logic       start,
  input  logic       btn_valid,
  input  logic [1:0] btn,
  output logic [3:0] led,
  output logic       awaiting_input,
  output logic       game_won,
  output logic       game_over,
  output logic [6:0] seq_len
);

  localparam int IDX_W = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int TMAX  = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
  localparam int TMR_W = (TMAX > 1) ? $clog2(TMAX) : 1;

  localparam logic [TMR_W-1:0] ON_LAST  = TMR_W'(ON_CYCLES - 1);
  localparam logic [TMR_W-1:0] OFF_LAST = TMR_W'(OFF_CYCLES - 1);
  localparam logic [6:0]       LEN_MAX  = 7'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXTEND,
    S_PLAY_ON,
    S_PLAY_OFF,
    S_WAIT_INPUT,
    S_WON,
    S_LOST
  } state_t;

  state_t             state_q, state_d;
  logic [6:0]         len_q, len_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [1:0]         mem_q [MAX_LEN];
  logic               mem_we;

  logic [1:0] cur_colour;
  logic       last_idx;

  assign cur_colour = mem_q[idx_q];
  assign last_idx   = (7'(idx_q) == (len_q - 7'd1));

  // Control registers; reset returns to IDLE with an empty sequence.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      idx_q   <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      timer_q <= timer_d;
    end
  end

  // Sequence memory has no reset: entries are only read after being written.
  always_ff @(posedge clock) begin
    if (mem_we) mem_q[len_q[IDX_W-1:0]] <= rand_num;
  end

  // Next-state logic for the game FSM, playback timer and index.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    timer_d = timer_q;
    mem_we  = 1'b0;
    case (state_q)
      S_IDLE, S_WON, S_LOST: begin
        if (start) begin
          len_d   = '0;
          state_d = S_EXTEND;
        end
      end
      S_EXTEND: begin
        // EXTEND is only entered while len < MAX_LEN, so the write slot exists.
        mem_we  = 1'b1;
        len_d   = len_q + 7'd1;
        idx_d   = '0;
        timer_d = '0;
        state_d = S_PLAY_ON;
      end
      S_PLAY_ON: begin
        if (timer_q == ON_LAST) begin
          timer_d = '0;
          state_d = S_PLAY_OFF;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_PLAY_OFF: begin
        if (timer_q == OFF_LAST) begin
          timer_d = '0;
          if (last_idx) begin
            idx_d   = '0;
            state_d = S_WAIT_INPUT;
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = S_PLAY_ON;
          end
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      S_WAIT_INPUT: begin
        // start is deliberately not looked at here; a press always wins.
        if (btn_valid) begin
          if (btn != cur_colour) begin
            state_d = S_LOST;
          end else if (!last_idx) begin
            idx_d = idx_q + IDX_W'(1);
          end else if (len_q == LEN_MAX) begin
            state_d = S_WON;
          end else begin
            state_d = S_EXTEND;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore output decode from registered state, length and current entry.
  always_comb begin
    led            = 4'b0000;
    awaiting_input = 1'b0;
    game_won       = 1'b0;
    game_over      = 1'b0;
    seq_len        = len_q;
    case (state_q)
      S_PLAY_ON:    led = 4'b0001 << cur_colour;
      S_WAIT_INPUT: awaiting_input = 1'b1;
      S_WON: begin
        game_won = 1'b1;
        led      = 4'b1111;
      end
      S_LOST:       game_over = 1'b1;
      default:      led = 4'b0000;
    endcase
  end

endmodule

// File: doc/simon_sequencer.md
# simon_sequencer

- Game-sequence engine for the Simon Says design; sits directly downstream of the free-running 2-bit random-number generator.
- On each new round it samples the generator's current value and appends it to a stored colour sequence.
- It then plays the whole sequence back on four one-hot LED outputs and checks the player's button presses against it.
- It reports whether the player won or lost.

## Interface
Parameters:
- MAX_LEN, 16, longest sequence; reaching it with a correct final entry wins (range 1–64)
- ON_CYCLES, 25_000_000, cycles each playback LED is lit (≥1)
- OFF_CYCLES, 12_500_000, dark cycles after each playback step (≥1)

Ports:
- clock  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low; forces IDLE immediately
- rand_num  input  2  current value from the random-number generator, sampled only in EXTEND
- start  input  1  begin new game; single-cycle pulse, honoured in IDLE/WON/LOST only
- btn_valid  input  1  single-cycle pulse: player pressed a button
- btn  input  2  colour index of the pressed button, valid with btn_valid
- led  output  4  one-hot playback LED (bit n ⇔ colour n); all-ones in WON, 0 otherwise
- awaiting_input  output  1  high in WAIT_INPUT
- game_won  output  1  high in WON
- game_over  output  1  high in LOST
- seq_len  output  7  current sequence length (0..MAX_LEN)

## Operation
- Storage: MAX_LEN×2-bit sequence memory; registers for len, idx and a playback timer sized for max(ON_CYCLES, OFF_CYCLES).
- All outputs are Moore decodes of registered state, len and mem[idx].
- States and transitions:
  - IDLE: led=0. On start: len←0, go to EXTEND.
  - EXTEND (1 cycle): mem[len]←rand_num; len←len+1; idx←0; timer←0; go to PLAY_ON.
  - PLAY_ON: led=onehot(mem[idx]). timer counts 0..ON_CYCLES−1; at ON_CYCLES−1: timer←0, go to PLAY_OFF.
  - PLAY_OFF: led=0. At OFF_CYCLES−1: timer←0.
    - If idx==len−1: idx←0, go to WAIT_INPUT.
    - Else: idx←idx+1, go to PLAY_ON.
  - WAIT_INPUT: awaiting_input=1; btn_valid is acted on.
    - btn≠mem[idx]: go to LOST.
    - btn==mem[idx] and idx<len−1: idx←idx+1.
    - btn==mem[idx] and idx==len−1: go to WON if len==MAX_LEN, else go to EXTEND.
  - WON: game_won=1, led=4'b1111. On start: len←0, go to EXTEND.
  - LOST: game_over=1, led=0. On start: len←0, go to EXTEND.
- Ignored inputs:
  - btn_valid outside WAIT_INPUT.
  - start in EXTEND, PLAY_ON, PLAY_OFF and WAIT_INPUT.
  - start and btn_valid asserted together in WAIT_INPUT: btn_valid is processed, start is ignored.
- No input timeout: WAIT_INPUT holds indefinitely.

## Timing
- Reset (async, low): state=IDLE, len=0, idx=0, timer=0. All outputs 0 (led=0, awaiting_input=0, game_won=0, game_over=0, seq_len=0).
  - Memory is not cleared; its contents are don't-care until written.
  - Reset asserted mid-playback or mid-input aborts the game; outputs read 0 within the same cycle.
- start sampled at edge k → EXTEND after edge k.
- At edge k+1, rand_num is captured and the state becomes PLAY_ON; led is valid from edge k+1.
- Each step: led lit for exactly ON_CYCLES cycles, then 0 for exactly OFF_CYCLES cycles.
- Full playback of length L lasts L×(ON_CYCLES+OFF_CYCLES) cycles; awaiting_input rises on the edge ending the last OFF period.
- btn_valid sampled at edge j:
  - Mismatch: LOST (game_over=1) after edge j.
  - Correct final entry: EXTEND after edge j, new step captured at edge j+1, playback starts after edge j+1.
- seq_len updates on the EXTEND edge, one edge after entering EXTEND.

## Test plan
- ON=3, OFF=2, MAX_LEN=4. Reset low mid-PLAY_ON → all outputs 0 immediately; after release, state IDLE, seq_len=0.
- start with rand_num=2 → led=4'b0100 for 3 cycles, then 0 for 2 cycles; then awaiting_input=1, seq_len=1.
- Round 1 value 2, press btn=2 → EXTEND captures rand_num=1; playback 0100, 0000, 0010, 0000 (3/2/3/2 cycles); awaiting_input=1, seq_len=2.
- In WAIT_INPUT with sequence {2,1}: press 2 then 3 → game_over=1 after the second press, led=0. start → seq_len=1 and new playback.
- Four correct rounds with MAX_LEN=4 → after the 4th correct entry, game_won=1, led=4'b1111, seq_len=4; no EXTEND.
- btn_valid pulses during PLAY_ON/PLAY_OFF and start pulses mid-playback → ignored; playback timing and idx unchanged.
